// File: rtl/id_sequence_detector.sv
// Receiver-side checker for the 8-digit ID sequence: a Moore FSM tracks match progress
// and raises registered match, mismatch and inter-digit timeout pulses.
module id_sequence_detector #(
    parameter logic [3:0] ID0     = 4'h0,
    parameter logic [3:0] ID1     = 4'h1,
    parameter logic [3:0] ID2     = 4'h2,
    parameter logic [3:0] ID3     = 4'h4,
    parameter logic [3:0] ID4     = 4'h2,
    parameter logic [3:0] ID5     = 4'h8,
    parameter logic [3:0] ID6     = 4'h6,
    parameter logic [3:0] ID7     = 4'h5,
    parameter int         GAP_MAX = 16,
    parameter int         COUNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [3:0]         digit_in,
    input  logic               digit_valid,
    input  logic               clear_count,
    output logic [3:0]         detect_state,
    output logic               match_pulse,
    output logic               mismatch_pulse,
    output logic               timeout_pulse,
    output logic [COUNT_W-1:0] match_count
);

    typedef enum logic [2:0] {
        S0, S1, S2, S3, S4, S5, S6, S7
    } state_t;

    // Gap counter wraps to S0 on the cycle it would reach GAP_MAX.
    localparam logic [7:0] GAP_LAST = 8'(GAP_MAX - 1);

    state_t             r_state;
    state_t             w_next_state;
    logic [7:0]         r_gap;
    logic [7:0]         w_next_gap;
    logic               r_match;
    logic               r_mismatch;
    logic               r_timeout;
    logic               w_next_match;
    logic               w_next_mismatch;
    logic               w_next_timeout;
    logic [COUNT_W-1:0] r_count;
    logic [COUNT_W-1:0] w_next_count;
    logic [3:0]         w_expected;

    always_comb begin
        w_expected = ID0;
        case (r_state)
            S0: w_expected = ID0;
            S1: w_expected = ID1;
            S2: w_expected = ID2;
            S3: w_expected = ID3;
            S4: w_expected = ID4;
            S5: w_expected = ID5;
            S6: w_expected = ID6;
            S7: w_expected = ID7;
            default: w_expected = ID0;
        endcase
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_gap      = r_gap;
        w_next_match    = 1'b0;
        w_next_mismatch = 1'b0;
        w_next_timeout  = 1'b0;
        w_next_count    = r_count;

        if (digit_valid) begin
            w_next_gap = 8'd0;
            if (digit_in == w_expected) begin
                if (r_state == S7) begin
                    w_next_state = S0;
                    w_next_match = 1'b1;
                    if (r_count != {COUNT_W{1'b1}}) begin
                        w_next_count = r_count + COUNT_W'(1);
                    end
                end else begin
                    w_next_state = state_t'(r_state + 3'd1);
                end
            end else begin
                // A wrong digit may itself be a fresh start of the sequence.
                w_next_mismatch = 1'b1;
                w_next_state    = (digit_in == ID0) ? S1 : S0;
            end
        end else if (r_state != S0) begin
            if (r_gap == GAP_LAST) begin
                w_next_state   = S0;
                w_next_timeout = 1'b1;
                w_next_gap     = 8'd0;
            end else begin
                w_next_gap = r_gap + 8'd1;
            end
        end else begin
            w_next_gap = 8'd0;
        end

        if (clear_count) begin
            w_next_count = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= S0;
            r_gap      <= 8'd0;
            r_match    <= 1'b0;
            r_mismatch <= 1'b0;
            r_timeout  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_next_state;
            r_gap      <= w_next_gap;
            r_match    <= w_next_match;
            r_mismatch <= w_next_mismatch;
            r_timeout  <= w_next_timeout;
            r_count    <= w_next_count;
        end
    end

    assign detect_state   = {1'b0, r_state};
    assign match_pulse    = r_match;
    assign mismatch_pulse = r_mismatch;
    assign timeout_pulse  = r_timeout;
    assign match_count    = r_count;

endmodule

// File: tb/tb_id_sequence_detector.sv
// Directed self-checking bench for id_sequence_detector with default parameters
// (ID 0,1,2,4,2,8,6,5; GAP_MAX=16; COUNT_W=8).
module tb_id_sequence_detector;

    logic       clock;
    logic       reset;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       clear_count;
    logic [3:0] detect_state;
    logic       match_pulse;
    logic       mismatch_pulse;
    logic       timeout_pulse;
    logic [7:0] match_count;

    int checks   = 0;
    int failures = 0;

    logic [3:0] idSeq [8];
    logic [7:0] expCount;
    int         gapLen;

    id_sequence_detector dut (
        .clock          (clock),
        .reset          (reset),
        .digit_in       (digit_in),
        .digit_valid    (digit_valid),
        .clear_count    (clear_count),
        .detect_state   (detect_state),
        .match_pulse    (match_pulse),
        .mismatch_pulse (mismatch_pulse),
        .timeout_pulse  (timeout_pulse),
        .match_count    (match_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs, then settle just after the sampling edge.
    task automatic applyStimulus(input logic v, input logic [3:0] d, input logic clr);
        digit_valid = v;
        digit_in    = d;
        clear_count = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] expState,
                               input logic expMatch, input logic expMis,
                               input logic expTo, input logic [7:0] expCnt);
        logic [14:0] obs;
        logic [14:0] exp;
        obs = {detect_state, match_pulse, mismatch_pulse, timeout_pulse, match_count};
        exp = {expState, expMatch, expMis, expTo, expCnt};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h (state,m,mm,to,count)", tag, obs, exp);
        end
    endtask

    initial begin
        idSeq = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h2, 4'h8, 4'h6, 4'h5};
        reset       = 1'b0;
        digit_in    = 4'h0;
        digit_valid = 1'b0;
        clear_count = 1'b0;
        expCount    = 8'd0;

        applyStimulus(1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkOutput("reset_state", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        #2 reset = 1'b1;

        // Full sequence on consecutive cycles
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, idSeq[i], 1'b0);
            checkOutput("full_seq", 4'((i + 1) % 8), (i == 7), 1'b0, 1'b0, (i == 7) ? 8'd1 : 8'd0);
        end
        applyStimulus(1'b0, 4'h0, 1'b0);
        checkOutput("after_match_idle", 4'd0, 1'b0, 1'b0, 1'b0, 8'd1);

        // Mismatch mid-sequence, then restart on a repeated first digit
        applyStimulus(1'b1, 4'h0, 1'b0); checkOutput("mm_s1", 4'd1, 1'b0, 1'b0, 1'b0, 8'd1);
        applyStimulus(1'b1, 4'h1, 1'b0); checkOutput("mm_s2", 4'd2, 1'b0, 1'b0, 1'b0, 8'd1);
        applyStimulus(1'b1, 4'h2, 1'b0); checkOutput("mm_s3", 4'd3, 1'b0, 1'b0, 1'b0, 8'd1);
        applyStimulus(1'b1, 4'h7, 1'b0); checkOutput("mm_bad7", 4'd0, 1'b0, 1'b1, 1'b0, 8'd1);
        applyStimulus(1'b1, 4'h0, 1'b0); checkOutput("mm_first0", 4'd1, 1'b0, 1'b0, 1'b0, 8'd1);
        applyStimulus(1'b1, 4'h0, 1'b0); checkOutput("mm_second0", 4'd1, 1'b0, 1'b1, 1'b0, 8'd1);

        // Timeout after 16 idle cycles in S2
        applyStimulus(1'b1, 4'h1, 1'b0); checkOutput("to_s2", 4'd2, 1'b0, 1'b0, 1'b0, 8'd1);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b0, 4'h0, 1'b0);
            checkOutput("to_idle_hold", 4'd2, 1'b0, 1'b0, 1'b0, 8'd1);
        end
        applyStimulus(1'b0, 4'h0, 1'b0); checkOutput("to_fire", 4'd0, 1'b0, 1'b0, 1'b1, 8'd1);
        applyStimulus(1'b0, 4'h0, 1'b0); checkOutput("to_after", 4'd0, 1'b0, 1'b0, 1'b0, 8'd1);
        applyStimulus(1'b1, 4'h3, 1'b0); checkOutput("s0_mismatch", 4'd0, 1'b0, 1'b1, 1'b0, 8'd1);

        // Digit arriving on the 16th idle cycle beats the timeout
        applyStimulus(1'b1, 4'h0, 1'b0); checkOutput("nto_s1", 4'd1, 1'b0, 1'b0, 1'b0, 8'd1);
        applyStimulus(1'b1, 4'h1, 1'b0); checkOutput("nto_s2", 4'd2, 1'b0, 1'b0, 1'b0, 8'd1);
        for (int i = 1; i <= 15; i++) begin
            applyStimulus(1'b0, 4'h0, 1'b0);
        end
        checkOutput("nto_idle15", 4'd2, 1'b0, 1'b0, 1'b0, 8'd1);
        applyStimulus(1'b1, 4'h2, 1'b0); checkOutput("nto_s3", 4'd3, 1'b0, 1'b0, 1'b0, 8'd1);
        applyStimulus(1'b1, 4'h4, 1'b0); checkOutput("nto_s4", 4'd4, 1'b0, 1'b0, 1'b0, 8'd1);
        applyStimulus(1'b1, 4'h2, 1'b0); checkOutput("nto_s5", 4'd5, 1'b0, 1'b0, 1'b0, 8'd1);

        // Asynchronous reset between edges while in S5
        digit_valid = 1'b0;
        #3 reset = 1'b0;
        #1 checkOutput("async_reset", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        #2 reset = 1'b1;
        applyStimulus(1'b0, 4'h0, 1'b0); checkOutput("post_reset1", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        applyStimulus(1'b0, 4'h0, 1'b0); checkOutput("post_reset2", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Saturation: 299 matches, then the 300th with clear_count
        for (int m = 1; m <= 299; m++) begin
            for (int i = 0; i < 8; i++) begin
                applyStimulus(1'b1, idSeq[i], 1'b0);
            end
            if (m == 1 || m == 254 || m == 255 || m == 256 || m == 299) begin
                checkOutput("sat_count", 4'd0, 1'b1, 1'b0, 1'b0, (m > 255) ? 8'd255 : 8'(m));
            end
        end
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, idSeq[i], 1'b0);
        end
        checkOutput("sat_pre_final", 4'd7, 1'b0, 1'b0, 1'b0, 8'd255);
        applyStimulus(1'b1, idSeq[7], 1'b1);
        checkOutput("clear_beats_inc", 4'd0, 1'b1, 1'b0, 1'b0, 8'd0);

        // Plain clear with no match in flight
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, idSeq[i], 1'b0);
        end
        checkOutput("count_one", 4'd0, 1'b1, 1'b0, 1'b0, 8'd1);
        applyStimulus(1'b0, 4'h0, 1'b1);
        checkOutput("clear_only", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Random idle gaps below GAP_MAX with X on digit_in while invalid
        expCount = 8'd0;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 8; i++) begin
                gapLen = int'($urandom_range(15, 0));
                for (int g = 0; g < gapLen; g++) begin
                    applyStimulus(1'b0, 4'bxxxx, 1'b0);
                    checkOutput("rand_idle", 4'(i), 1'b0, 1'b0, 1'b0, expCount);
                end
                applyStimulus(1'b1, idSeq[i], 1'b0);
                if (i == 7) expCount = expCount + 8'd1;
                checkOutput("rand_digit", 4'((i + 1) % 8), (i == 7), 1'b0, 1'b0, expCount);
            end
        end
        applyStimulus(1'b0, 4'bxxxx, 1'b0);
        checkOutput("rand_end", 4'd0, 1'b0, 1'b0, 1'b0, 8'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_sequence_detector.md
Name: id_sequence_detector

Overview:
- Receiver-side counterpart of the 8-state ID sequencer.
- Accepts a stream of 4-bit digits qualified by a valid strobe and tracks progress through the programmed 8-digit ID sequence with a Moore FSM.
- Pulses on each complete match, counts matches and flags mismatches and inter-digit timeouts.
- Used on the bench and on-chip to confirm that the sequencer/display path emits digits in the correct order.

Parameters:
- ID0..ID7, defaults 4'h0,4'h1,4'h2,4'h4,4'h2,4'h8,4'h6,4'h5: expected digit for steps 0..7.
- GAP_MAX, default 16: maximum idle cycles between valid digits while a match is in progress (1..255).
- COUNT_W, default 8: width of the match counter.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; low clears all state immediately.
- digit_in  input  4  candidate digit.
- digit_valid  input  1  digit_in is sampled on a rising edge when high.
- clear_count  input  1  synchronous clear of match_count.
- detect_state  output  4  current FSM state, 4'd0..4'd7; equals the number of digits matched so far.
- match_pulse  output  1  one-cycle pulse after the 8th digit matches.
- mismatch_pulse  output  1  one-cycle pulse after a valid digit fails to match.
- timeout_pulse  output  1  one-cycle pulse after the gap limit is exceeded.
- match_count  output  COUNT_W  number of completed matches; saturates.

Behaviour:
- Reset (reset low, asynchronous):
  - detect_state=0; all pulses=0; match_count=0; gap counter=0.
  - Reset asserted mid-sequence discards progress; there is no pulse on release.
- States S0..S7 (detect_state = index). All outputs are registered (Moore); no combinational path from input to output.
- Valid digit, digit_in == ID[state]:
  - state<7: next state = state+1.
  - state==7: next state = S0, match_pulse=1 next cycle, match_count+1.
- Valid digit, digit_in != ID[state]:
  - mismatch_pulse=1 next cycle.
  - Next state = S1 if digit_in==ID0, else S0 (restart on a fresh first digit).
  - In S0 with digit_in != ID0: stays S0, mismatch_pulse still fires.
- digit_valid low: state holds.
- Gap counter:
  - Resets to 0 on every valid digit. Idles at 0 in S0.
  - Increments each cycle without a valid digit while in S1..S7.
  - When it reaches GAP_MAX: next state = S0, timeout_pulse=1, counter=0.
  - If digit_valid is high in that same cycle, the digit is processed normally and no timeout occurs.
- Matches are non-overlapping: after a full match, the next digit is compared against ID0.
- match_count:
  - Saturates at all-ones; further matches still pulse match_pulse.
  - clear_count has priority over an increment in the same cycle: result is 0.
- Pulse exclusivity: at most one of match/mismatch/timeout pulses is high in any cycle.
- Latency: the response (state, pulses) is visible exactly 1 clock after the sampling edge.
- digit_in is ignored when digit_valid is low, including X values.

Test Plan:
- Reset low, then release. Stream 0,1,2,4,2,8,6,5 on consecutive cycles -> detect_state 1..7 then 0; match_pulse high one cycle after the 8th digit; match_count=1.
- Stream 0,1,2,7 -> mismatch_pulse one cycle after the 7, state S0. Then 0,0 -> first 0 gives S1; second 0 mismatches, mismatch_pulse=1, next state S1.
- Stream 0,1, then 16 idle cycles (GAP_MAX=16) -> timeout_pulse after the 16th idle cycle, state S0. Repeat with the next digit arriving on the 16th idle cycle -> no timeout, state S3.
- Pull reset low asynchronously (between edges) while in S5 -> detect_state=0 and match_count=0 immediately; no pulses after release.
- Run 300 full matches with COUNT_W=8 -> match_count saturates at 255. Assert clear_count in the same cycle as the final match -> match_count=0.
- Digits spaced by random idle gaps below GAP_MAX, digit_in driven X while invalid -> exactly one match_pulse per full sequence; no X on any output.
